// File: rtl/intctl_pkg.sv
// Shared definitions for the multi-channel Unibus interrupt requester:
// FSM state encoding, the per-channel "no request" marker and vector formatting.
package intctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SACK,
        ST_INTR
    } state_t;

    // Bit 0 of a channel's vector byte carries this value when it is not requesting.
    localparam logic NO_REQ = 1'b1;

    function automatic logic [15:0] fmt_vec(input logic [7:0] vec);
        return {8'h00, vec[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/intarb.sv
// Combinational request picker: fixed priority (lowest index wins) or
// round-robin starting one past the last serviced channel when RR_EN is set.
module intarb #(
    parameter int NCHAN = 4,
    parameter int IW    = 2,
    parameter bit RR_EN = 1'b0
) (
    input  logic [NCHAN-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    // In fixed-priority builds the pointer is tied off and not consulted.
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    int j;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            j = RR_EN ? (int'(ptr) + 1 + i) : i;
            if (j >= NCHAN) begin
                j = j - NCHAN;
            end
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/intctl_multi.sv
// Multi-channel interrupt requester sharing one Unibus BR/BG level.
// Define INTCTL_RR_EN for round-robin arbitration; default is fixed priority.
module intctl_multi
    import intctl_pkg::*;
#(
    parameter int NCHAN  = 4,
    parameter int DGLCNT = 4
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [8*NCHAN-1:0]   intvecs,
    input  logic                 bbsy_in_h,
    input  logic                 bg_in_l,
    input  logic                 sack_in_h,
    input  logic                 ssyn_in_h,
    output logic                 bbsy_out_h,
    output logic                 bg_out_l,
    output logic                 br_out_h,
    output logic [15:0]          d_out_h,
    output logic                 intr_out_h,
    output logic                 sack_out_h,
    output logic [NCHAN-1:0]     intack
);

    localparam int CW = (DGLCNT > 0) ? $clog2(DGLCNT + 1) : 1;
    localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic [NCHAN-1:0] req;
    logic [7:0]       vec_arr [NCHAN];

    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_chan
            assign vec_arr[gi] = intvecs[8*gi +: 8];
            assign req[gi]     = (intvecs[8*gi] != NO_REQ);
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              br_reg, br_next;
    logic              sack_reg, sack_next;
    logic              bbsy_reg, bbsy_next;
    logic              intr_reg, intr_next;
    logic [15:0]       d_reg, d_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [NCHAN-1:0]  intack_reg, intack_next;
    logic [IW-1:0]     ptr_reg, ptr_next;
    logic              win_valid;
    logic [IW-1:0]     win_idx;

`ifdef INTCTL_RR_EN
    localparam bit RR = 1'b1;
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    localparam bit RR = 1'b0;
    assign ptr_reg = '0;
`endif

    intarb #(
        .NCHAN (NCHAN),
        .IW    (IW),
        .RR_EN (RR)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // SACK from another master is not used by a requester; kept for bus completeness.
    logic unused_sack_in;
    assign unused_sack_in = sack_in_h;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        br_next     = br_reg;
        sack_next   = sack_reg;
        bbsy_next   = bbsy_reg;
        intr_next   = intr_reg;
        d_next      = d_reg;
        idx_next    = idx_reg;
        intack_next = '0;
        ptr_next    = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                // A low grant here belongs to someone downstream; do not steal it.
                if ((|req) && bg_in_l) begin
                    br_next    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bg_in_l) begin
                    cnt_next = '0;
                end else if (cnt_reg != CW'(DGLCNT)) begin
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    br_next    = 1'b0;
                    sack_next  = 1'b1;
                    state_next = ST_SACK;
                end
            end
            ST_SACK: begin
                if (!bbsy_in_h && bg_in_l && !ssyn_in_h) begin
                    sack_next = 1'b0;
                    if (win_valid) begin
                        idx_next   = win_idx;
                        bbsy_next  = 1'b1;
                        intr_next  = 1'b1;
                        d_next     = fmt_vec(vec_arr[win_idx]);
                        state_next = ST_INTR;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_INTR: begin
                if (ssyn_in_h) begin
                    bbsy_next            = 1'b0;
                    intr_next            = 1'b0;
                    d_next               = '0;
                    intack_next[idx_reg] = 1'b1;
                    ptr_next             = idx_reg;
                    state_next           = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            br_reg     <= 1'b0;
            sack_reg   <= 1'b0;
            bbsy_reg   <= 1'b0;
            intr_reg   <= 1'b0;
            d_reg      <= '0;
            idx_reg    <= '0;
            intack_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            br_reg     <= br_next;
            sack_reg   <= sack_next;
            bbsy_reg   <= bbsy_next;
            intr_reg   <= intr_next;
            d_reg      <= d_next;
            idx_reg    <= idx_next;
            intack_reg <= intack_next;
        end
    end

    assign bbsy_out_h = bbsy_reg;
    assign br_out_h   = br_reg;
    assign bg_out_l   = br_reg | bg_in_l;
    assign sack_out_h = sack_reg;
    assign intr_out_h = intr_reg;
    assign d_out_h    = d_reg;
    assign intack     = intack_reg;

endmodule

// File: tb/tb_intctl_multi.sv
// Scoreboard bench for intctl_multi: expected (vector, intack) pairs are queued
// when a request is raised and popped when the DUT takes bus mastership.
module tb_intctl_multi;

    localparam int NCHAN  = 4;
    localparam int DGLCNT = 4;
    localparam logic [31:0] IDLE_VECS = 32'h0101_0101;

    typedef struct {
        logic [7:0]       vec;
        logic [NCHAN-1:0] ack;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [8*NCHAN-1:0] intvecs = IDLE_VECS;
    logic               bbsy_in_h = 1'b0;
    logic               bg_in_l = 1'b1;
    logic               sack_in_h = 1'b0;
    logic               ssyn_in_h = 1'b0;
    logic               bbsy_out_h, bg_out_l, br_out_h, intr_out_h, sack_out_h;
    logic [15:0]        d_out_h;
    logic [NCHAN-1:0]   intack;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb_q[$];

    intctl_multi #(.NCHAN(NCHAN), .DGLCNT(DGLCNT)) dut (
        .CLOCK      (clk),
        .RESET      (rst),
        .intvecs    (intvecs),
        .bbsy_in_h  (bbsy_in_h),
        .bg_in_l    (bg_in_l),
        .sack_in_h  (sack_in_h),
        .ssyn_in_h  (ssyn_in_h),
        .bbsy_out_h (bbsy_out_h),
        .bg_out_l   (bg_out_l),
        .br_out_h   (br_out_h),
        .d_out_h    (d_out_h),
        .intr_out_h (intr_out_h),
        .sack_out_h (sack_out_h),
        .intack     (intack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] vec, input logic [NCHAN-1:0] ack);
        exp_t e;
        e.vec = vec;
        e.ack = ack;
        sb_q.push_back(e);
    endtask

    task automatic set_chan(input int ch, input logic [7:0] vec);
        intvecs[8*ch +: 8] = vec;
    endtask

    task automatic chk_all_clear(input string tag);
        chk({tag, "_out"}, {bbsy_out_h, br_out_h, intr_out_h, sack_out_h, d_out_h},
            32'h0);
        chk({tag, "_intack"}, 32'(intack), 32'h0);
    endtask

    // Waits (bounded) for BR, then holds BG low exactly DGLCNT+1 cycles.
    task automatic grant();
        int n = 0;
        while (!br_out_h && n < 20) begin
            step();
            n++;
        end
        chk("br_up", 32'(br_out_h), 32'h1);
        bg_in_l = 1'b0;
        repeat (DGLCNT) step();
        chk("sack_early", 32'(sack_out_h), 32'h0);
        step();
        chk("sack_up", 32'(sack_out_h), 32'h1);
        chk("br_drop", 32'(br_out_h), 32'h0);
    endtask

    // From SACK: release grant, check the vector, then complete with SSYN.
    task automatic finish_service();
        exp_t e;
        logic [31:0] saved;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
            return;
        end
        e = sb_q.pop_front();
        bg_in_l = 1'b1;
        step();
        chk("intr_bbsy_sack", {bbsy_out_h, intr_out_h, sack_out_h}, 32'h6);
        chk("vec", 32'(d_out_h), {16'h0, 8'h00, e.vec[7:2], 2'b00});
        saved = intvecs;
        intvecs = intvecs ^ 32'hFCFC_FCFC;
        step();
        chk("vec_hold", 32'(d_out_h), {16'h0, 8'h00, e.vec[7:2], 2'b00});
        intvecs = saved;
        ssyn_in_h = 1'b1;
        step();
        chk("intack", 32'(intack), 32'(e.ack));
        chk("clr_out", {bbsy_out_h, intr_out_h, d_out_h}, 32'h0);
        ssyn_in_h = 1'b0;
        for (int k = 0; k < NCHAN; k++) begin
            if (e.ack[k]) set_chan(k, 8'h01);
        end
        step();
        chk("intack_pulse", 32'(intack), 32'h0);
    endtask

    initial begin
        exp_t drop;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_clear("reset");
        chk("bg_pass_hi", 32'(bg_out_l), 32'h1);
        bg_in_l = 1'b0;
        #1;
        chk("bg_pass_lo", 32'(bg_out_l), 32'h0);
        bg_in_l = 1'b1;
        step();

        // Basic service of channel 2, vector 0o124.
        set_chan(2, 8'o124);
        push(8'o124, 4'b0100);
        step();
        chk("br_latency", 32'(br_out_h), 32'h1);
        grant();
        finish_service();

        // Grant glitch on channel 1: 3 low, 1 high, then 5 low.
        set_chan(1, 8'h44);
        push(8'h44, 4'b0010);
        step();
        chk("glitch_br", 32'(br_out_h), 32'h1);
        bg_in_l = 1'b0;
        repeat (3) step();
        bg_in_l = 1'b1;
        step();
        chk("glitch_sack", {br_out_h, sack_out_h, bg_out_l}, 32'h5);
        bg_in_l = 1'b0;
        repeat (4) step();
        chk("glitch_sack4", {br_out_h, sack_out_h, bg_out_l}, 32'h5);
        step();
        chk("glitch_sack5", 32'(sack_out_h), 32'h1);
        finish_service();

        // Two simultaneous requesters: channel 1 (0o60) and channel 3 (0o70).
        set_chan(1, 8'o60);
        set_chan(3, 8'o70);
`ifdef INTCTL_RR_EN
        push(8'o70, 4'b1000);
        push(8'o60, 4'b0010);
`else
        push(8'o60, 4'b0010);
        push(8'o70, 4'b1000);
`endif
        grant();
        finish_service();
        grant();
        finish_service();

        // Withdrawal while in SACK.
        set_chan(0, 8'h10);
        grant();
        set_chan(0, 8'h01);
        bg_in_l = 1'b1;
        step();
        chk("wd_sack", {bbsy_out_h, intr_out_h, sack_out_h}, 32'h0);
        step();
        chk_all_clear("wd_idle");

        // Grant already propagating downstream when the request appears.
        bg_in_l = 1'b0;
        step();
        set_chan(1, 8'h2C);
        push(8'h2C, 4'b0010);
        repeat (3) step();
        chk("ds_br", {br_out_h, bg_out_l}, 32'h0);
        bg_in_l = 1'b1;
        step();
        chk("ds_br_up", 32'(br_out_h), 32'h1);
        grant();
        finish_service();

        // Reset while in INTR, then a fresh request.
        set_chan(3, 8'o70);
        grant();
        bg_in_l = 1'b1;
        if (sb_q.size() == 0) drop = '{8'h0, '0};
        step();
        chk("pre_rst_intr", 32'(intr_out_h), 32'h1);
        set_chan(3, 8'h01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_clear("rst_intr");
        step();
        chk_all_clear("rst_after");
        set_chan(0, 8'h20);
        push(8'h20, 4'b0001);
        grant();
        finish_service();

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
